// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO burst reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DW_DEF = 16;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream of the burst reader.
// Latency: n/a (wiring only).
// Backpressure: m_ready stalls the stream; fifo_empty stalls FIFO reads.
interface fifo_reader_if import fifo_pkg::*; #(
  parameter int DW = DW_DEF
);

  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  // Reader side: consumes FIFO, produces the stream.
  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  // Environment side: owns the FIFO and the downstream sink.
  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_skid2.sv
// Two-entry in-order skid buffer between FIFO read data and the stream.
// Latency: push visible at head one cycle later; pop frees an entry next cycle.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module fifo_skid2 import fifo_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [1:0]    occupancy,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem0;
  logic [DW-1:0] mem1;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // Guard against popping empty or overfilling; a simultaneous pop makes room.
  assign pop_ok  = pop && (occupancy != 2'd0);
  assign push_ok = push && ((occupancy != 2'd2) || pop_ok);
  assign head    = rd_ptr ? mem1 : mem0;

  // Storage, pointers and occupancy; same-cycle push+pop leaves occupancy alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0      <= '0;
      mem1      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push_ok) begin
        if (wr_ptr) mem1 <= din;
        else        mem0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Reads a burst of len words from a FIFO and streams them out over valid/ready.
// Latency: first m_valid two cycles after the edge sampling start; then 1 word/cycle.
// Backpressure: m_ready low stalls output; reads throttle so at most 2 words are held.
module fifo_reader import fifo_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          r_clk,
  input  logic          rrst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  fifo_reader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] rd_count
);

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued;
  logic          in_flight;
  logic [1:0]    occ;
  logic [DW-1:0] head;
  logic          xfer;
  logic          rd_en;
  logic [2:0]    eff_occ;

  assign xfer = bus.m_valid && bus.m_ready;

  // Words held after this edge: buffered plus in flight, minus one leaving now.
  // Counting the concurrent pop is what sustains one word per cycle.
  assign eff_occ = {1'b0, occ} + {2'b00, in_flight} - {2'b00, xfer};

  assign rd_en = (state == READ) && !bus.fifo_empty &&
                 (issued < len_q) && (eff_occ < 3'd2);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = head;

  fifo_skid2 #(.DW(DW)) u_skid (
    .clk       (r_clk),
    .rst_n     (rrst_n),
    .push      (in_flight),
    .pop       (xfer),
    .din       (bus.fifo_dout),
    .occupancy (occ),
    .head      (head)
  );

  // Burst FSM with its counters and registered busy/done outputs.
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_q     <= '0;
      issued    <= '0;
      rd_count  <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= rd_en;
      // done trails the DONE state by one register stage.
      done      <= (state == DONE);
      if (rd_en) issued   <= issued + 1'b1;
      if (xfer)  rd_count <= rd_count + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            issued   <= '0;
            rd_count <= '0;
            if (len == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= READ;
              busy  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issued == len_q) state <= DRAIN;
        end
        DRAIN: begin
          if ((rd_count == len_q) && (occ == 2'd0)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
